pipeline_run_controller: RTL and testbench



---
 rtl/run_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 31 +++
 rtl/pipeline_run_controller.sv | 154 +++++++++++++++
 tb/tb_pipeline_run_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the pipeline run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } run_state_t;

  localparam logic [31:0] PASS_CODE = 32'h1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next_c
);

  // Next value is exposed so the owner can act on the post-increment count.
  always_comb begin
    count_next_c = count;
    if (clr) begin
      count_next_c = '0;
    end else if (en && (count != {W{1'b1}})) begin
      count_next_c = count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/pipeline_run_controller.sv
// Sequences core reset, counts RUN cycles/retires and ends a test on tohost, budget or stall.
// Define RUN_CTRL_STALL_WDT_EN to build the retire-gap stall watchdog.
module pipeline_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 100,
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter int unsigned STALL_LIMIT  = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_Retire,
  input  logic             i_MemWrite,
  input  logic [31:0]      i_MemAddr,
  input  logic [31:0]      i_MemWData,
  output logic             o_CoreReset_n,
  output logic             o_Running,
  output logic             o_Done,
  output logic             o_Pass,
  output logic             o_Timeout,
  output logic             o_Stall,
  output logic [30:0]      o_FailCode,
  output logic [CNT_W-1:0] o_CycleCount,
  output logic [CNT_W-1:0] o_RetireCount
);

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_t       state;
  logic [RST_W-1:0] rst_cnt;
  logic             start_clr;
  logic             in_run;
  logic             tohost_hit;
  logic             stall_hit;
  logic             timeout_hit;
  logic [CNT_W-1:0] cycle_next;
  logic [CNT_W-1:0] retire_next_unused;
  logic [1:0]       unused_addr_lsb;

  assign unused_addr_lsb = i_MemAddr[1:0];

  assign in_run    = (state == RUN);
  assign start_clr = i_Start && ((state == IDLE) || (state == DONE));

  assign tohost_hit  = in_run && i_MemWrite && (i_MemAddr[31:2] == TOHOST_ADDR[31:2]) && i_MemWData[0];
  assign timeout_hit = in_run && (cycle_next == CNT_W'(MAX_CYCLES));

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk          (i_Clk),
    .rst          (i_Reset),
    .clr          (start_clr),
    .en           (in_run),
    .count        (o_CycleCount),
    .count_next_c (cycle_next)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk          (i_Clk),
    .rst          (i_Reset),
    .clr          (start_clr),
    .en           (in_run && i_Retire),
    .count        (o_RetireCount),
    .count_next_c (retire_next_unused)
  );

`ifdef RUN_CTRL_STALL_WDT_EN
  localparam int unsigned GAP_W = $clog2(STALL_LIMIT + 1);

  logic [GAP_W-1:0] gap_count_unused;
  logic [GAP_W-1:0] gap_next;

  // Gap restarts on every retire and whenever the core is outside RUN.
  sat_counter #(.W(GAP_W)) u_gap_cnt (
    .clk          (i_Clk),
    .rst          (i_Reset),
    .clr          (!in_run || i_Retire),
    .en           (in_run),
    .count        (gap_count_unused),
    .count_next_c (gap_next)
  );

  assign stall_hit = in_run && (gap_next == GAP_W'(STALL_LIMIT));
`else
  logic unused_stall_limit;
  assign unused_stall_limit = (STALL_LIMIT == 0);
  assign stall_hit          = 1'b0;
`endif

  // Run-state sequencer; all status outputs are registered here.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= IDLE;
      rst_cnt       <= '0;
      o_CoreReset_n <= 1'b0;
      o_Running     <= 1'b0;
      o_Done        <= 1'b0;
      o_Pass        <= 1'b0;
      o_Timeout     <= 1'b0;
      o_Stall       <= 1'b0;
      o_FailCode    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_Start) begin
            state         <= RESET;
            rst_cnt       <= '0;
            o_CoreReset_n <= 1'b0;
            o_Running     <= 1'b0;
            o_Done        <= 1'b0;
            o_Pass        <= 1'b0;
            o_Timeout     <= 1'b0;
            o_Stall       <= 1'b0;
            o_FailCode    <= '0;
          end
        end
        RESET: begin
          if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
            state         <= RUN;
            o_CoreReset_n <= 1'b1;
            o_Running     <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        RUN: begin
          // Coincident events resolve as hit, then stall, then timeout.
          if (tohost_hit) begin
            state      <= DONE;
            o_Running  <= 1'b0;
            o_Done     <= 1'b1;
            o_Pass     <= (i_MemWData == PASS_CODE);
            o_FailCode <= i_MemWData[31:1];
          end else if (stall_hit) begin
            state     <= DONE;
            o_Running <= 1'b0;
            o_Done    <= 1'b1;
            o_Pass    <= 1'b0;
            o_Stall   <= 1'b1;
          end else if (timeout_hit) begin
            state     <= DONE;
            o_Running <= 1'b0;
            o_Done    <= 1'b1;
            o_Timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Scoreboard bench: planned random runs, expected end-of-test results from a cycle-level reference model.
module tb_pipeline_run_controller;

  localparam int unsigned RESET_CYCLES = 2;
  localparam int unsigned MAX_CYCLES   = 100;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned STALL_LIMIT  = 16;
  localparam int          LEN          = MAX_CYCLES + 8;
`ifdef RUN_CTRL_STALL_WDT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic             i_Clk = 1'b0;
  logic             i_Reset = 1'b1;
  logic             i_Start = 1'b0;
  logic             i_Retire = 1'b0;
  logic             i_MemWrite = 1'b0;
  logic [31:0]      i_MemAddr = '0;
  logic [31:0]      i_MemWData = '0;
  logic             o_CoreReset_n, o_Running, o_Done, o_Pass, o_Timeout, o_Stall;
  logic [30:0]      o_FailCode;
  logic [CNT_W-1:0] o_CycleCount, o_RetireCount;

  pipeline_run_controller #(
    .RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W),
    .TOHOST_ADDR(32'h0000_1000), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Retire(i_Retire),
    .i_MemWrite(i_MemWrite), .i_MemAddr(i_MemAddr), .i_MemWData(i_MemWData),
    .o_CoreReset_n(o_CoreReset_n), .o_Running(o_Running), .o_Done(o_Done),
    .o_Pass(o_Pass), .o_Timeout(o_Timeout), .o_Stall(o_Stall),
    .o_FailCode(o_FailCode), .o_CycleCount(o_CycleCount), .o_RetireCount(o_RetireCount)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int          cyc;
    int          ret;
    bit          pass;
    bit          to;
    bit          st;
    logic [30:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done_q = 1'b0;

  bit          p_ret   [0:LEN-1];
  bit          p_wr    [0:LEN-1];
  bit          p_start [0:LEN-1];
  logic [31:0] p_addr  [0:LEN-1];
  logic [31:0] p_data  [0:LEN-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Random background traffic that never qualifies as a tohost hit.
  task automatic build_plan(input int kind);
    int hk;
    for (int k = 0; k < LEN; k++) begin
      p_ret[k]   = (kind == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      p_wr[k]    = ($urandom_range(0, 4) == 0);
      p_start[k] = ($urandom_range(0, 7) == 0);
      p_data[k]  = $urandom;
      case ($urandom_range(0, 3))
        0: begin p_addr[k] = 32'h0000_1000 | 32'($urandom_range(0, 3)); p_data[k][0] = 1'b0; end
        1: p_addr[k] = 32'h0000_1004;
        2: p_addr[k] = 32'h0000_0FFC;
        default: p_addr[k] = $urandom;
      endcase
      if (p_addr[k][31:2] == 30'h400) p_data[k][0] = 1'b0;
    end
    hk = 0;
    case (kind)
      0: begin
        hk = $urandom_range(1, MAX_CYCLES);
        p_data[hk] = ($urandom_range(0, 1) == 0) ? 32'h1 : ($urandom | 32'h1);
      end
      2: begin hk = MAX_CYCLES; p_data[hk] = 32'h1; end
      4: begin hk = 37; p_data[hk] = 32'h1; end
      5: begin
        hk = $urandom_range(5, 60);
        p_data[hk] = 32'h7;
        p_wr[hk-2] = 1'b1; p_addr[hk-2] = 32'h0000_1000; p_data[hk-2] = 32'h6;
      end
      default: hk = 0;
    endcase
    if (hk != 0) begin
      p_wr[hk]   = 1'b1;
      p_addr[hk] = 32'h0000_1000 | 32'($urandom_range(0, 3));
    end
  endtask

  // Reference: walk RUN cycles 1.. and apply the end-of-test rules directly.
  function automatic exp_t model();
    exp_t e;
    int   gap;
    bit   hit;
    e   = '{cyc: 0, ret: 0, pass: 1'b0, to: 1'b0, st: 1'b0, fc: '0};
    gap = 0;
    for (int k = 1; k < LEN; k++) begin
      e.cyc = k;
      if (p_ret[k]) begin e.ret++; gap = 0; end
      else gap++;
      hit = p_wr[k] && (p_addr[k] >= 32'h1000) && (p_addr[k] < 32'h1004) && p_data[k][0];
      if (hit) begin
        e.pass = (p_data[k] == 32'h1);
        e.fc   = p_data[k][31:1];
        return e;
      end
      if (STALL_EN && gap == int'(STALL_LIMIT)) begin e.st = 1'b1; return e; end
      if (k == int'(MAX_CYCLES)) begin e.to = 1'b1; return e; end
    end
    return e;
  endfunction

  task automatic idle_inputs();
    i_Start = 1'b0; i_Retire = 1'b0; i_MemWrite = 1'b0; i_MemAddr = '0; i_MemWData = '0;
  endtask

  task automatic start_and_wait_run(input bit check_it);
    int low;
    @(negedge i_Clk); i_Start = 1'b1;
    @(negedge i_Clk); i_Start = 1'b0;
    low = 0;
    while (o_CoreReset_n == 1'b0 && low < 20) begin
      low++;
      @(negedge i_Clk);
    end
    if (check_it) begin
      chk("core_reset_low_cycles", 64'(low), 64'(RESET_CYCLES));
      chk("running_after_reset", {63'd0, o_Running}, 64'd1);
    end
  endtask

  task automatic run_test(input int kind);
    exp_t e;
    bit   seen;
    build_plan(kind);
    e = model();
    exp_q.push_back(e);
    start_and_wait_run(1'b1);
    seen = 1'b0;
    for (int k = 1; k < LEN && !seen; k++) begin
      i_Retire = p_ret[k]; i_MemWrite = p_wr[k]; i_MemAddr = p_addr[k];
      i_MemWData = p_data[k]; i_Start = p_start[k];
      @(negedge i_Clk);
      seen = o_Done;
    end
    idle_inputs();
    if (!seen) chk("done_within_budget", 64'd0, 64'd1);
    @(negedge i_Clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, {27'd0, o_CoreReset_n, o_Running, o_Done, o_Pass, o_Timeout, o_Stall, o_FailCode}, 64'd0);
    chk({name, "_counts"}, {o_CycleCount, o_RetireCount}, 64'd0);
  endtask

  // Monitor: compare the final status whenever o_Done rises.
  always @(negedge i_Clk) begin
    if (o_Done && !done_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cycle_count", 64'(o_CycleCount), 64'(e.cyc));
        chk("retire_count", 64'(o_RetireCount), 64'(e.ret));
        chk("pass", 64'(o_Pass), 64'(e.pass));
        chk("timeout", 64'(o_Timeout), 64'(e.to));
        chk("stall", 64'(o_Stall), 64'(e.st));
        chk("fail_code", 64'(o_FailCode), 64'(e.fc));
        chk("core_reset_n_in_done", 64'(o_CoreReset_n), 64'd1);
      end
    end
    done_q = o_Done;
  end

  initial begin
    idle_inputs();
    i_Reset = 1'b1;
    repeat (2) @(negedge i_Clk);
    chk_all_zero("reset_state");
    i_Reset = 1'b0;

    run_test(4);
    run_test(5);
    run_test(1);
    run_test(2);
    run_test(3);
    for (int t = 0; t < 12; t++) run_test(0);

    // Reset in the middle of RUN returns everything to zero.
    start_and_wait_run(1'b0);
    repeat (5) begin i_Retire = 1'b1; @(negedge i_Clk); end
    i_Retire = 1'b0; i_Reset = 1'b1;
    @(negedge i_Clk); i_Reset = 1'b0;
    chk_all_zero("reset_mid_run");

    run_test(4);

    // Reset and start together from DONE: reset wins and IDLE holds.
    i_Reset = 1'b1; i_Start = 1'b1;
    @(negedge i_Clk); i_Reset = 1'b0; i_Start = 1'b0;
    chk_all_zero("reset_with_start");
    @(negedge i_Clk);
    chk_all_zero("idle_holds");

    run_test(0);
    repeat (3) @(negedge i_Clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
